// File: rtl/bin2bcd_feeder.sv
// Sequential double-dabble binary-to-BCD converter feeding the 4-digit display.
// Optional fixed decimal point enabled by defining BCD_DOT_EN (position DP_POS).
module bin2bcd_feeder #(
  parameter int unsigned IN_WIDTH = 14,
  parameter int unsigned DP_POS   = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [15:0]         value,
  output logic [3:0]          dots
);

  localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_WIDTH - 1);

  // An out-of-range decimal-point index is a build error rather than a silent blank.
  if (DP_POS > 3) begin : g_bad_dp_pos
    $error("DP_POS must be in 0..3");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic                   w_shift;
  logic                   w_update;
  logic                   w_busy_nxt;
  logic                   w_bin_ovf;
  logic [15:0]            w_adj;
  logic [IN_WIDTH+15:0]   w_cat;

  logic                   r_busy;
  logic                   r_done;
  logic                   r_ovf;
  logic [15:0]            r_value;
  logic [15:0]            r_bcd;
  logic [IN_WIDTH-1:0]    r_bin;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ovf_pend;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_cnt == LAST_SHIFT) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state datapath controls and next value of the registered flags
  always_comb begin
    w_accept = 1'b0;
    w_shift  = 1'b0;
    w_update = 1'b0;
    case (r_state)
      S_IDLE:   w_accept = start;
      S_SHIFT:  w_shift  = 1'b1;
      S_UPDATE: w_update = 1'b1;
      default:  ;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign w_bin_ovf = (32'(bin) > 32'd9999);

  // Add-3 correction on every nibble >= 5, then shift {bcd, bin} left by one
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_cat = {w_adj, r_bin} << 1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_value    <= 16'h0000;
      r_bcd      <= 16'h0000;
      r_bin      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_update;
      if (w_accept) begin
        r_bin      <= bin;
        r_bcd      <= 16'h0000;
        r_cnt      <= '0;
        r_ovf_pend <= w_bin_ovf;
      end
      if (w_shift) begin
        r_bcd <= w_cat[IN_WIDTH+15:IN_WIDTH];
        r_bin <= w_cat[IN_WIDTH-1:0];
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_update) begin
        r_value <= r_ovf_pend ? 16'hFFFF : r_bcd;
        r_ovf   <= r_ovf_pend;
      end
    end
  end

`ifdef BCD_DOT_EN
  localparam logic [3:0] DOT_MASK = 4'b0001 << DP_POS;
  logic [3:0] r_dots;

  // Fixed decimal point, blanked when the display shows the overflow pattern
  always_ff @(posedge clock) begin
    if (!reset_n)      r_dots <= 4'b0000;
    else if (w_update) r_dots <= r_ovf_pend ? 4'b0000 : DOT_MASK;
  end

  assign dots = r_dots;
`else
  assign dots = 4'b0000;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign value    = r_value;

endmodule

// File: tb/tb_bin2bcd_feeder.sv
// Bench for bin2bcd_feeder: cycle-level behavioural model with per-cycle compare,
// directed boundary conversions and randomized start/bin/reset traffic.
module tb_bin2bcd_feeder;

  localparam int unsigned W  = 14;
  localparam int unsigned DP = 2;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic [W-1:0]  bin     = '0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [15:0]   value;
  logic [3:0]    dots;

  bin2bcd_feeder #(.IN_WIDTH(W), .DP_POS(DP)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .value    (value),
    .dots     (dots)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain arithmetic; anything above 9999 is the FFFF pattern
  function automatic logic [15:0] bcd_of(input int unsigned v);
    if (v > 9999) return 16'hFFFF;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] dots_of(input int unsigned v);
`ifdef BCD_DOT_EN
    if (v > 9999) return 4'b0000;
    return 4'(1 << DP);
`else
    if (v > 9999) return 4'b0000;
    return 4'b0000;
`endif
  endfunction

  // Behavioural model: a conversion accepted while idle completes W+1 edges later
  int          m_cnt   = 0;
  int unsigned m_bin   = 0;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_value = 16'h0000;
  logic [3:0]  m_dots  = 4'b0000;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_cnt = 0; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
      m_value = 16'h0000; m_dots = 4'b0000;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_bin = int'(bin);
          m_cnt = W + 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done  = 1'b1;
          m_value = bcd_of(m_bin);
          m_ovf   = (m_bin > 9999);
          m_dots  = dots_of(m_bin);
        end
      end
      m_busy = (m_cnt != 0);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy",     32'(busy),     32'(m_busy));
      check("done",     32'(done),     32'(m_done));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("value",    32'(value),    32'(m_value));
      check("dots",     32'(dots),     32'(m_dots));
    end
  end

  task automatic wait_done(output int cyc, output int nb, output bit seen);
    cyc = 0; nb = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cyc++;
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic conv(input int unsigned b, input logic [15:0] exp_val, input logic exp_ovf,
                      input logic [3:0] exp_dots);
    int cyc, nb;
    bit seen;
    int nbusy;
    @(negedge clock);
    bin = W'(b);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    nbusy = busy ? 1 : 0;
    wait_done(cyc, nb, seen);
    check("done_seen",   32'(seen), 32'd1);
    check("latency",     32'(cyc), 32'd15);
    check("busy_cycles", 32'(nbusy + nb), 32'd15);
    check("conv_value",  32'(value), 32'(exp_val));
    check("conv_ovf",    32'(overflow), 32'(exp_ovf));
    check("conv_dots",   32'(dots), 32'(exp_dots));
    @(negedge clock);
    check("done_pulse",  32'(done), 32'd0);
  endtask

  initial begin
    int cyc, nb, ndone;
    bit seen;
    logic [3:0] dot_1234;

`ifdef BCD_DOT_EN
    dot_1234 = 4'b0100;
`else
    dot_1234 = 4'b0000;
`endif

    repeat (2) @(negedge clock);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_value",    32'(value),    32'h0000);
    check("rst_dots",     32'(dots),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    conv(1234,  16'h1234, 1'b0, dot_1234);
    conv(0,     16'h0000, 1'b0, dot_1234);
    conv(9999,  16'h9999, 1'b0, dot_1234);
    conv(10000, 16'hFFFF, 1'b1, 4'b0000);
    conv(16383, 16'hFFFF, 1'b1, 4'b0000);

    // Held start with bin changing mid-conversion; start coinciding with done is taken
    @(negedge clock);
    bin = W'(4321);
    start = 1'b1;
    @(negedge clock);
    bin = W'(55);
    wait_done(cyc, nb, seen);
    check("held_done1",  32'(seen),  32'd1);
    check("held_value1", 32'(value), 32'h4321);
    @(negedge clock);
    start = 1'b0;
    check("held_busy2",  32'(busy),  32'd1);
    wait_done(cyc, nb, seen);
    check("held_done2",  32'(seen),  32'd1);
    check("held_value2", 32'(value), 32'h0055);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clock);
    bin = W'(8765);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_value", 32'(value), 32'h0000);
    ndone = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // Random traffic with boundary-biased values and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      start   = ($urandom % 3) == 0;
      reset_n = ($urandom % 250) != 0;
      case ($urandom % 8)
        0:       bin = W'(9999);
        1:       bin = W'(10000);
        2:       bin = W'(0);
        default: bin = W'($urandom_range(0, 16383));
      endcase
    end
    @(negedge clock);
    reset_n = 1'b1;
    start = 1'b0;
    repeat (20) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
